// File: rtl/s298_state_ctrl.sv
// State register, scan path and single-shot bit-flip injector wrapped around the
// combinational s298 core. Modes: IDLE hold, RUN capture ns_in, SCAN shift.
module s298_state_ctrl #(
    parameter int NBITS = 14,
    parameter int CNT_W = 16
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             run_en,
    input  logic             scan_en,
    input  logic             scan_in,
    output logic             scan_out,
    input  logic [NBITS-1:0] ns_in,
    output logic [NBITS-1:0] ps_out,
    input  logic             cnt_clr,
    input  logic             inj_arm,
    input  logic [CNT_W-1:0] inj_cycle,
    input  logic [NBITS-1:0] inj_mask,
    output logic             inj_armed,
    output logic             inj_done,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [1:0]       mode
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        SCAN = 2'b10
    } mode_t;

    mode_t            r_mode;
    mode_t            w_mode_nxt;
    logic [NBITS-1:0] r_ps;
    logic [CNT_W-1:0] r_cnt;
    logic             r_armed;
    logic [CNT_W-1:0] r_tgt_cycle;
    logic [NBITS-1:0] r_tgt_mask;
    logic             r_done;
    logic             w_fire;
    logic [NBITS-1:0] w_flip;

    always_ff @(posedge CK or posedge RST) begin
        if (RST) r_mode <= IDLE;
        else     r_mode <= w_mode_nxt;
    end

    always_comb begin
        w_mode_nxt = IDLE;
        if (scan_en)     w_mode_nxt = SCAN;
        else if (run_en) w_mode_nxt = RUN;
    end

    // Compare against the pre-increment count so a target of N fires on the N->N+1 capture.
    assign w_fire = (r_mode == RUN) && r_armed && (r_cnt == r_tgt_cycle);
    assign w_flip = w_fire ? r_tgt_mask : '0;

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_ps <= '0;
        end else begin
            case (r_mode)
                RUN:     r_ps <= ns_in ^ w_flip;
                SCAN:    r_ps <= {r_ps[NBITS-2:0], scan_in};
                default: r_ps <= r_ps;
            endcase
        end
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST)                r_cnt <= '0;
        else if (cnt_clr)       r_cnt <= '0;
        else if (r_mode == RUN) r_cnt <= r_cnt + 1'b1;
    end

    // A new arm on the firing edge wins the armed flag; the old target still fires this edge.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_armed     <= 1'b0;
            r_tgt_cycle <= '0;
            r_tgt_mask  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_fire;
            if (inj_arm) begin
                r_armed     <= 1'b1;
                r_tgt_cycle <= inj_cycle;
                r_tgt_mask  <= inj_mask;
            end else if (w_fire) begin
                r_armed <= 1'b0;
            end
        end
    end

    assign ps_out    = r_ps;
    assign scan_out  = r_ps[NBITS-1];
    assign cycle_cnt = r_cnt;
    assign mode      = r_mode;
    assign inj_armed = r_armed;
    assign inj_done  = r_done;

endmodule

// File: tb/tb_s298_state_ctrl.sv
// Directed bench for s298_state_ctrl: reset, RUN capture, scan round trip,
// injection, arm-on-fire and counter wrap (second instance with a 4-bit counter).
module tb_s298_state_ctrl;

    logic        CK = 1'b0;
    logic        RST = 1'b0;
    logic        run_en = 1'b0, scan_en = 1'b0, scan_in = 1'b0;
    logic        cnt_clr = 1'b0, inj_arm = 1'b0;
    logic [15:0] inj_cycle = '0;
    logic [13:0] inj_mask = '0, ns_in = '0;
    logic        scan_out, inj_armed, inj_done;
    logic [13:0] ps_out;
    logic [15:0] cycle_cnt;
    logic [1:0]  mode;

    logic        run_en4 = 1'b0, inj_arm4 = 1'b0;
    logic [3:0]  inj_cycle4 = '0;
    logic [13:0] inj_mask4 = '0, ns_in4 = '0;
    logic        scan_out4, inj_armed4, inj_done4;
    logic [13:0] ps_out4;
    logic [3:0]  cycle_cnt4;
    logic [1:0]  mode4;

    int n_pass = 0;
    int n_total = 0;

    always #5 CK = ~CK;

    s298_state_ctrl #(.NBITS(14), .CNT_W(16)) dut (
        .CK(CK), .RST(RST), .run_en(run_en), .scan_en(scan_en), .scan_in(scan_in),
        .scan_out(scan_out), .ns_in(ns_in), .ps_out(ps_out), .cnt_clr(cnt_clr),
        .inj_arm(inj_arm), .inj_cycle(inj_cycle), .inj_mask(inj_mask),
        .inj_armed(inj_armed), .inj_done(inj_done), .cycle_cnt(cycle_cnt), .mode(mode)
    );

    s298_state_ctrl #(.NBITS(14), .CNT_W(4)) dut4 (
        .CK(CK), .RST(RST), .run_en(run_en4), .scan_en(1'b0), .scan_in(1'b0),
        .scan_out(scan_out4), .ns_in(ns_in4), .ps_out(ps_out4), .cnt_clr(1'b0),
        .inj_arm(inj_arm4), .inj_cycle(inj_cycle4), .inj_mask(inj_mask4),
        .inj_armed(inj_armed4), .inj_done(inj_done4), .cycle_cnt(cycle_cnt4), .mode(mode4)
    );

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic test_reset();
        #2 RST = 1'b1;
        #1;
        n_total++;
        if ({ps_out, cycle_cnt, mode, inj_armed, inj_done, scan_out} !== '0)
            $display("FAIL reset_vals ps=%h cnt=%0d mode=%b armed=%b done=%b so=%b (want all 0)",
                     ps_out, cycle_cnt, mode, inj_armed, inj_done, scan_out);
        else n_pass++;
        step();
        RST = 1'b0;
        step();
    endtask

    task automatic test_run();
        ns_in = 14'h2A5;
        run_en = 1'b1;
        step();
        n_total++;
        if (mode !== 2'b01 || ps_out !== 14'h0 || cycle_cnt !== 16'd0)
            $display("FAIL run_entry mode=%b ps=%h cnt=%0d (want 01 0000 0)", mode, ps_out, cycle_cnt);
        else n_pass++;
        step();
        n_total++;
        if (ps_out !== 14'h2A5 || cycle_cnt !== 16'd1)
            $display("FAIL run_first_capture ps=%h cnt=%0d (want 2a5 1)", ps_out, cycle_cnt);
        else n_pass++;
        step(); step(); step();
        n_total++;
        if (cycle_cnt !== 16'd4)
            $display("FAIL run_cnt5 cnt=%0d (want 4)", cycle_cnt);
        else n_pass++;
        run_en = 1'b0;
        ns_in = 14'h1111;
        step();
        n_total++;
        if (mode !== 2'b00 || cycle_cnt !== 16'd5 || ps_out !== 14'h1111)
            $display("FAIL run_exit mode=%b cnt=%0d ps=%h (want 00 5 1111)", mode, cycle_cnt, ps_out);
        else n_pass++;
        ns_in = 14'h0222;
        step();
        n_total++;
        if (cycle_cnt !== 16'd5 || ps_out !== 14'h1111)
            $display("FAIL idle_hold cnt=%0d ps=%h (want 5 1111)", cycle_cnt, ps_out);
        else n_pass++;
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        n_total++;
        if (cycle_cnt !== 16'd0)
            $display("FAIL cnt_clr cnt=%0d (want 0)", cycle_cnt);
        else n_pass++;
    endtask

    task automatic test_scan();
        logic [13:0] pat;
        logic [13:0] got;
        pat = 14'h3C81;
        got = '0;
        ns_in = '0;
        scan_en = 1'b1;
        run_en = 1'b1;
        step();
        n_total++;
        if (mode !== 2'b10 || ps_out !== 14'h1111)
            $display("FAIL scan_entry mode=%b ps=%h (want 10 1111)", mode, ps_out);
        else n_pass++;
        for (int i = 13; i >= 0; i--) begin
            scan_in = pat[i];
            step();
        end
        n_total++;
        if (ps_out !== 14'h3C81 || cycle_cnt !== 16'd0)
            $display("FAIL scan_load ps=%h cnt=%0d (want 3c81 0)", ps_out, cycle_cnt);
        else n_pass++;
        scan_in = 1'b0;
        for (int i = 13; i >= 0; i--) begin
            got[i] = scan_out;
            step();
        end
        n_total++;
        if (got !== 14'h3C81)
            $display("FAIL scan_unload seq=%h (want 3c81)", got);
        else n_pass++;
        n_total++;
        if (ps_out !== 14'h0)
            $display("FAIL scan_empty ps=%h (want 0)", ps_out);
        else n_pass++;
        scan_en = 1'b0;
        run_en = 1'b0;
        step();
    endtask

    task automatic test_inject();
        cnt_clr = 1'b1;
        inj_arm = 1'b1;
        inj_cycle = 16'd3;
        inj_mask = 14'h0001;
        ns_in = '0;
        step();
        cnt_clr = 1'b0;
        inj_arm = 1'b0;
        n_total++;
        if (inj_armed !== 1'b1 || cycle_cnt !== 16'd0)
            $display("FAIL inj_arm armed=%b cnt=%0d (want 1 0)", inj_armed, cycle_cnt);
        else n_pass++;
        run_en = 1'b1;
        step();
        step(); step(); step();
        n_total++;
        if (cycle_cnt !== 16'd3 || ps_out !== 14'h0 || inj_done !== 1'b0 || inj_armed !== 1'b1)
            $display("FAIL inj_prefire cnt=%0d ps=%h done=%b armed=%b (want 3 0 0 1)",
                     cycle_cnt, ps_out, inj_done, inj_armed);
        else n_pass++;
        step();
        n_total++;
        if (cycle_cnt !== 16'd4 || ps_out !== 14'h0001 || inj_done !== 1'b1 || inj_armed !== 1'b0)
            $display("FAIL inj_fire cnt=%0d ps=%h done=%b armed=%b (want 4 0001 1 0)",
                     cycle_cnt, ps_out, inj_done, inj_armed);
        else n_pass++;
        step();
        n_total++;
        if (ps_out !== 14'h0 || inj_done !== 1'b0)
            $display("FAIL inj_single ps=%h done=%b (want 0 0)", ps_out, inj_done);
        else n_pass++;
        run_en = 1'b0;
        step();
    endtask

    task automatic test_arm_on_fire();
        cnt_clr = 1'b1;
        inj_arm = 1'b1;
        inj_cycle = 16'd2;
        inj_mask = 14'h0004;
        ns_in = '0;
        step();
        cnt_clr = 1'b0;
        inj_arm = 1'b0;
        run_en = 1'b1;
        step();
        step(); step();
        inj_arm = 1'b1;
        inj_cycle = 16'd5;
        inj_mask = 14'h2000;
        step();
        inj_arm = 1'b0;
        n_total++;
        if (cycle_cnt !== 16'd3 || ps_out !== 14'h0004 || inj_done !== 1'b1 || inj_armed !== 1'b1)
            $display("FAIL aof_first cnt=%0d ps=%h done=%b armed=%b (want 3 0004 1 1)",
                     cycle_cnt, ps_out, inj_done, inj_armed);
        else n_pass++;
        step();
        n_total++;
        if (ps_out !== 14'h0 || inj_done !== 1'b0 || inj_armed !== 1'b1)
            $display("FAIL aof_gap ps=%h done=%b armed=%b (want 0 0 1)", ps_out, inj_done, inj_armed);
        else n_pass++;
        step();
        step();
        n_total++;
        if (cycle_cnt !== 16'd6 || ps_out !== 14'h2000 || inj_done !== 1'b1 || inj_armed !== 1'b0)
            $display("FAIL aof_second cnt=%0d ps=%h done=%b armed=%b (want 6 2000 1 0)",
                     cycle_cnt, ps_out, inj_done, inj_armed);
        else n_pass++;
        run_en = 1'b0;
        step();
    endtask

    task automatic test_wrap();
        int fires;
        int flips;
        fires = 0;
        flips = 0;
        inj_arm4 = 1'b1;
        inj_cycle4 = 4'd1;
        inj_mask4 = 14'h0001;
        step();
        inj_arm4 = 1'b0;
        run_en4 = 1'b1;
        step();
        for (int i = 1; i <= 20; i++) begin
            step();
            if (inj_done4 === 1'b1) fires++;
            if (ps_out4 !== 14'h0) flips++;
            if (i == 15 || i == 16) begin
                n_total++;
                if (cycle_cnt4 !== 4'(i))
                    $display("FAIL wrap_cnt_%0d cnt=%0d (want %0d)", i, cycle_cnt4, i % 16);
                else n_pass++;
            end
        end
        n_total++;
        if (cycle_cnt4 !== 4'd4)
            $display("FAIL wrap_final cnt=%0d (want 4)", cycle_cnt4);
        else n_pass++;
        n_total++;
        if (fires != 1 || flips != 1 || inj_armed4 !== 1'b0)
            $display("FAIL wrap_once fires=%0d flips=%0d armed=%b (want 1 1 0)", fires, flips, inj_armed4);
        else n_pass++;
        run_en4 = 1'b0;
        step();
    endtask

    task automatic test_reset_midrun();
        inj_arm = 1'b1;
        inj_cycle = 16'd100;
        inj_mask = 14'h3FFF;
        ns_in = 14'h155;
        run_en = 1'b1;
        step();
        inj_arm = 1'b0;
        step(); step();
        #2 RST = 1'b1;
        #1;
        n_total++;
        if (ps_out !== 14'h0 || cycle_cnt !== 16'd0 || mode !== 2'b00 || inj_armed !== 1'b0)
            $display("FAIL reset_async ps=%h cnt=%0d mode=%b armed=%b (want 0 0 00 0)",
                     ps_out, cycle_cnt, mode, inj_armed);
        else n_pass++;
        run_en = 1'b0;
        step();
        RST = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_run();
        test_scan();
        test_inject();
        test_arm_on_fire();
        test_wrap();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
